seq_divider_16by8: RTL and testbench

- Iterative restoring divider; the inverse of the 8x8 multiplier datapath.
- Takes a 16-bit dividend (e.g. a multiplier product) and an 8-bit divisor.
- Produces a 16-bit quotient and an 8-bit remainder after a fixed multi-cycle latency.
- Sits beside the multiplier behind the same pad wrapper; start/done handshake.

---
 rtl/seq_divider_16by8_pkg.sv | 26 ++
 rtl/seq_divider_16by8_if.sv | 44 ++++
 rtl/seq_divider_16by8_div_step.sv | 38 +++
 rtl/seq_divider_16by8.sv | 162 ++++++++++++++++
 tb/tb_seq_divider_16by8.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_16by8_pkg.sv
//------------------------------------------------------------------------------
// Module   : seq_div_pkg
// Brief    : Shared widths, FSM state type and constants for the 16/8
//            sequential restoring divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_div_pkg;

   localparam int N_W   = 16;   // dividend / quotient width
   localparam int D_W   = 8;    // divisor / remainder width
   localparam int CNT_W = 5;    // iteration counter, must hold N_W

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Quotient reported for a zero divisor
   localparam logic [N_W-1:0] DBZ_QUOTIENT = '1;

endpackage

`default_nettype wire

// File: rtl/seq_divider_16by8_if.sv
//------------------------------------------------------------------------------
// Module   : seq_divider_16by8_if
// Brief    : start/done handshake and operand/result bundle of the divider.
//            signed_mode exists only when SEQ_DIVIDER_SIGNED_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_divider_16by8_if #(
   parameter int N_W = seq_div_pkg::N_W,
   parameter int D_W = seq_div_pkg::D_W
) ();

   logic           start;
   logic [N_W-1:0] dividend;
   logic [D_W-1:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic           signed_mode;
`endif
   logic           busy;
   logic           done;
   logic [N_W-1:0] quotient;
   logic [D_W-1:0] remainder;
   logic           div_by_zero;

   modport master (
      output start, dividend, divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
      output signed_mode,
`endif
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
      input  signed_mode,
`endif
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

`default_nettype wire

// File: rtl/seq_divider_16by8_div_step.sv
//------------------------------------------------------------------------------
// Module   : div_step
// Brief    : One combinational restoring-division iteration: shift {R,Q}
//            left, subtract the divisor when it fits, shift the result bit
//            into Q[0].
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_step #(
   parameter int N_W = 16,
   parameter int D_W = 8
) (
   input  wire logic [D_W:0]   r_in,
   input  wire logic [N_W-1:0] q_in,
   input  wire logic [D_W-1:0] divisor,
   output logic      [D_W:0]   r_out,
   output logic      [N_W-1:0] q_out
);

   logic [D_W:0] w_shifted;
   logic [D_W:0] w_diff;
   logic         w_fits;

   // Shift, trial-subtract and restore. The top bit of r_in is always zero
   // after a restoring step, but it is folded into the compare so the
   // 10-bit shifted value is handled exactly.
   always_comb begin
      w_shifted = {r_in[D_W-1:0], q_in[N_W-1]};
      w_fits    = r_in[D_W] | (w_shifted >= {1'b0, divisor});
      w_diff    = w_shifted - {1'b0, divisor};
      r_out     = w_fits ? w_diff : w_shifted;
      q_out     = {q_in[N_W-2:0], w_fits};
   end

endmodule

`default_nettype wire

// File: rtl/seq_divider_16by8.sv
//------------------------------------------------------------------------------
// Module   : seq_divider_16by8
// Brief    : Iterative 16/8 restoring divider with start/done handshake.
//            16 iterations, done at T+17; divide-by-zero answers at T+1.
//            Define SEQ_DIVIDER_SIGNED_EN to add two's-complement operation
//            (signed_mode input, sign fixup applied as results are loaded).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider_16by8
   import seq_div_pkg::*;
#(
   parameter int N_W = seq_div_pkg::N_W,
   parameter int D_W = seq_div_pkg::D_W
) (
   input wire logic         clk,
   input wire logic         rst,
   seq_divider_16by8_if.slave bus
);

   state_t           r_state;
   logic [D_W:0]     r_rem;       // 9-bit partial remainder
   logic [N_W-1:0]   r_q;         // dividend shifting out / quotient in
   logic [D_W-1:0]   r_dsr;       // divisor magnitude
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [N_W-1:0]   r_quotient;
   logic [D_W-1:0]   r_remainder;
   logic             r_dbz;

   logic [N_W-1:0]   w_dvd_mag;
   logic [D_W-1:0]   w_dsr_mag;
   logic [D_W:0]     w_r_nxt;
   logic [N_W-1:0]   w_q_nxt;
   logic [N_W-1:0]   w_q_fin;
   logic [D_W-1:0]   w_r_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic             w_dvd_neg;
   logic             w_dsr_neg;
   logic             r_q_neg;     // quotient negative: operand signs differ
   logic             r_r_neg;     // remainder follows the dividend sign
`endif

   // Operand magnitudes presented to the unsigned core at acceptance
   always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      w_dvd_neg = bus.signed_mode & bus.dividend[N_W-1];
      w_dsr_neg = bus.signed_mode & bus.divisor[D_W-1];
      w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
      w_dsr_mag = w_dsr_neg ? -bus.divisor  : bus.divisor;
`else
      w_dvd_mag = bus.dividend;
      w_dsr_mag = bus.divisor;
`endif
   end

   div_step #(
      .N_W (N_W),
      .D_W (D_W)
   ) u_step (
      .r_in    (r_rem),
      .q_in    (r_q),
      .divisor (r_dsr),
      .r_out   (w_r_nxt),
      .q_out   (w_q_nxt)
   );

   // Final results of the last iteration, sign-corrected when enabled
   always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      w_q_fin = r_q_neg ? -w_q_nxt : w_q_nxt;
      w_r_fin = r_r_neg ? -w_r_nxt[D_W-1:0] : w_r_nxt[D_W-1:0];
`else
      w_q_fin = w_q_nxt;
      w_r_fin = w_r_nxt[D_W-1:0];
`endif
   end

   // Control FSM, iteration datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rem       <= '0;
         r_q         <= '0;
         r_dsr       <= '0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_busy <= 1'b1;
                  if (bus.divisor == '0) begin
                     // Zero divisor: bypass the iterations entirely
                     r_state     <= DONE;
                     r_done      <= 1'b1;
                     r_quotient  <= N_W'(DBZ_QUOTIENT);
                     r_remainder <= bus.dividend[D_W-1:0];
                     r_dbz       <= 1'b1;
                  end else begin
                     r_state <= CALC;
                     r_rem   <= '0;
                     r_q     <= w_dvd_mag;
                     r_dsr   <= w_dsr_mag;
                     r_cnt   <= CNT_W'(N_W);
                     r_dbz   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                     r_q_neg <= w_dvd_neg ^ w_dsr_neg;
                     r_r_neg <= w_dvd_neg;
`endif
                  end
               end
            end

            CALC: begin
               r_rem <= w_r_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  // Last iteration: results appear together with done
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_quotient  <= w_q_fin;
                  r_remainder <= w_r_fin;
               end
            end

            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_16by8.sv
//------------------------------------------------------------------------------
// Module   : tb_seq_divider_16by8
// Brief    : Self-checking bench for seq_divider_16by8: directed corner
//            cases, handshake timing, abort by reset and random operands
//            against an arithmetic reference. Honours SEQ_DIVIDER_SIGNED_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider_16by8;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   seq_divider_16by8_if dif ();

   seq_divider_16by8 dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   always #5 clk = ~clk;

   // Free-running cycle count for spacing measurements
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: plain integer division, truncation toward zero
   function automatic void model(input logic [15:0] a, input logic [7:0] b, input logic sm,
                                 output logic [15:0] q, output logic [7:0] r,
                                 output logic dbz, output int lat);
      int sa;
      int sb;
      if (b == 8'd0) begin
         q = 16'hFFFF; r = a[7:0]; dbz = 1'b1; lat = 1;
      end else if (sm) begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         q = 16'(sa / sb); r = 8'(sa % sb); dbz = 1'b0; lat = 17;
      end else begin
         sa = int'(a);
         sb = int'(b);
         q = 16'(sa / sb); r = 8'(sa % sb); dbz = 1'b0; lat = 17;
      end
   endfunction

   task automatic drive(input logic [15:0] a, input logic [7:0] b, input logic sm);
      dif.dividend = a;
      dif.divisor  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
      dif.signed_mode = sm;
`else
      if (sm) dif.dividend = a;
`endif
   endtask

   // One operation; optional stray start pulse at negedge glitch_k (0 = none)
   task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic sm,
                         input int glitch_k, input string tag);
      logic [15:0] eq;
      logic [7:0]  er;
      logic        edbz;
      int          elat;
      int          k;
      int          gaps;
      bit          seen;
      model(a, b, sm, eq, er, edbz, elat);
      @(negedge clk);
      dif.start = 1'b1;
      drive(a, b, sm);
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      drive(16'($urandom), 8'($urandom), 1'($urandom));
      k = 0; gaps = 0; seen = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (k == glitch_k) begin
            dif.start = 1'b1;
            drive(16'($urandom), 8'($urandom_range(1, 255)), 1'($urandom));
         end else if (k == glitch_k + 1) begin
            dif.start = 1'b0;
         end
         if (dif.done) seen = 1;
         else if (!dif.busy) gaps++;
      end
      check({tag, " latency"}, seen ? k : 0, elat);
      check({tag, " busy gap"}, gaps, 0);
      check({tag, " busy@done"}, {31'd0, dif.busy}, 1);
      check({tag, " quotient"}, {16'd0, dif.quotient}, {16'd0, eq});
      check({tag, " remainder"}, {24'd0, dif.remainder}, {24'd0, er});
      check({tag, " dbz"}, {31'd0, dif.div_by_zero}, {31'd0, edbz});
      @(negedge clk);
      check({tag, " done pulse"}, {30'd0, dif.done, dif.busy}, 0);
      check({tag, " held q"}, {16'd0, dif.quotient}, {16'd0, eq});
   endtask

   task automatic wait_done(output int at, output bit ok);
      ok = 0;
      at = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (dif.done) begin
            ok = 1;
            at = cyc;
         end
      end
   endtask

   initial begin
      int  t1;
      int  t2;
      bit  ok1;
      bit  ok2;
      int  dcount;
      logic [7:0] rb;
      logic       rsm;

      rst = 1'b1;
      dif.start = 1'b0;
      drive(16'd0, 8'd0, 1'b0);
      repeat (2) @(negedge clk);
      check("rst busy", {31'd0, dif.busy}, 0);
      check("rst done", {31'd0, dif.done}, 0);
      check("rst quotient", {16'd0, dif.quotient}, 0);
      check("rst remainder", {24'd0, dif.remainder}, 0);
      check("rst dbz", {31'd0, dif.div_by_zero}, 0);
      rst = 1'b0;

      // Directed corner cases
      run_op(16'd45000, 8'd200, 1'b0, 0, "45000/200");
      run_op(16'd1000,  8'd7,   1'b0, 0, "1000/7");
      run_op(16'd65535, 8'd1,   1'b0, 0, "65535/1");
      run_op(16'd65535, 8'd255, 1'b0, 0, "65535/255");
      run_op(16'd5,     8'd9,   1'b0, 0, "5/9");
      run_op(16'h1234,  8'd0,   1'b0, 0, "1234/0");
      run_op(16'd100,   8'd10,  1'b0, 0, "100/10");
      run_op(16'd45000, 8'd200, 1'b0, 5, "stray start");

      // Back-to-back with start held high
      @(negedge clk);
      dif.start = 1'b1;
      drive(16'd1000, 8'd7, 1'b0);
      @(posedge clk);
      #1;
      drive(16'd45000, 8'd200, 1'b0);
      wait_done(t1, ok1);
      check("b2b first done", {31'd0, ok1}, 1);
      check("b2b first q", {16'd0, dif.quotient}, 142);
      check("b2b first r", {24'd0, dif.remainder}, 6);
      wait_done(t2, ok2);
      dif.start = 1'b0;
      check("b2b second done", {31'd0, ok2}, 1);
      check("b2b spacing", t2 - t1, 18);
      check("b2b second q", {16'd0, dif.quotient}, 225);
      check("b2b second r", {24'd0, dif.remainder}, 0);
      repeat (2) @(negedge clk);

      // Abort by asynchronous reset in the middle of the iterations
      @(negedge clk);
      dif.start = 1'b1;
      drive(16'd45000, 8'd200, 1'b0);
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      repeat (8) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort busy", {31'd0, dif.busy}, 0);
      check("abort done", {31'd0, dif.done}, 0);
      check("abort quotient", {16'd0, dif.quotient}, 0);
      check("abort remainder", {24'd0, dif.remainder}, 0);
      check("abort dbz", {31'd0, dif.div_by_zero}, 0);
      @(negedge clk);
      rst = 1'b0;
      dcount = 0;
      repeat (25) begin
         @(negedge clk);
         if (dif.done) dcount++;
      end
      check("abort no done", dcount, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
      run_op(16'hFC18, 8'd7,   1'b1, 0, "-1000/7");
      run_op(16'd1000, 8'hF9,  1'b1, 0, "1000/-7");
      run_op(16'h8000, 8'hFF,  1'b1, 0, "-32768/-1");
      run_op(16'h8000, 8'h80,  1'b1, 0, "-32768/-128");
      run_op(16'hFC18, 8'd0,   1'b1, 0, "signed dbz");
`endif

      // Random operands, occasional zero divisor
      for (int i = 0; i < 40; i++) begin
         rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
`ifdef SEQ_DIVIDER_SIGNED_EN
         rsm = 1'($urandom);
`else
         rsm = 1'b0;
`endif
         run_op(16'($urandom), rb, rsm, 0, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
